// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for seq_divider: operand request in, registered result out.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (adds a one-cycle sign FIX state).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  seq_divider_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t state, state_nxt;

  // The partial remainder is always below the divisor after each step,
  // so only WIDTH bits need storing; the extra bit lives in the subtract.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] dsr;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_by_zero_q;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

`ifdef SIGNED_DIV_EN
  logic sign_q;
  logic rem_neg;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  // Magnitude of the most negative value is representable as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg2c(x) : x;
  endfunction
`endif

  assign rs   = {r_acc, q_acc[WIDTH-1]};
  assign diff = rs - {1'b0, dsr};

  always_comb begin
    if (!diff[WIDTH]) begin
      r_step = diff[WIDTH-1:0];
      q_step = {q_acc[WIDTH-2:0], 1'b1};
    end else begin
      r_step = rs[WIDTH-1:0];
      q_step = {q_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
`ifdef SIGNED_DIV_EN
        if (count == '0) state_nxt = FIX;
`else
        if (count == '0) state_nxt = DONE;
`endif
      end
`ifdef SIGNED_DIV_EN
      FIX: begin
        bus.busy  = 1'b1;
        state_nxt = DONE;
      end
`endif
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers load on the edge that enters DONE, so they are valid
  // in the same cycle the done pulse is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc         <= '0;
      q_acc         <= '0;
      dsr           <= '0;
      count         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
`ifdef SIGNED_DIV_EN
      sign_q        <= 1'b0;
      rem_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              quotient_q    <= '1;
              remainder_q   <= bus.dividend;
              div_by_zero_q <= 1'b1;
            end else begin
              r_acc <= '0;
              count <= CNT_W'(WIDTH - 1);
`ifdef SIGNED_DIV_EN
              q_acc   <= mag(bus.dividend);
              dsr     <= mag(bus.divisor);
              sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              rem_neg <= bus.dividend[WIDTH-1];
`else
              q_acc <= bus.dividend;
              dsr   <= bus.divisor;
`endif
            end
          end
        end
        RUN: begin
          r_acc <= r_step;
          q_acc <= q_step;
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
`ifndef SIGNED_DIV_EN
            quotient_q    <= q_step;
            remainder_q   <= r_step;
            div_by_zero_q <= 1'b0;
`endif
          end
        end
`ifdef SIGNED_DIV_EN
        FIX: begin
          quotient_q    <= sign_q  ? neg2c(q_acc) : q_acc;
          remainder_q   <= rem_neg ? neg2c(r_acc) : r_acc;
          div_by_zero_q <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule
